// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and slice width.
// Optional subtract support is controlled by the NSA_ADDSUB_EN macro in the users of this package.
package nsa_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between the operand source and the nibble-serial adder.
// The op signal exists only when NSA_ADDSUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(parameter int NIBBLES = 4);

    logic                 start;
    logic [4*NIBBLES-1:0] a;
    logic [4*NIBBLES-1:0] b;
    logic                 cin;
`ifdef NSA_ADDSUB_EN
    logic                 op;
`endif
    logic                 busy;
    logic                 done;
    logic [4*NIBBLES-1:0] sum;
    logic                 cout;
    logic                 ovf;

`ifdef NSA_ADDSUB_EN
    modport master (output start, a, b, cin, op, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, op, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4_slice.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells;
// the controller reuses this single slice for every nibble.
module adder4_slice
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add (and, with NSA_ADDSUB_EN, subtract) sequencer around one 4-bit slice.
// Operands are latched on start, processed LSB nibble first, result reported with busy/done.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                       clk,
    input  logic                       resetn,
    nibble_serial_adder_ctrl_if.slave  bus
);

    localparam int W    = NIB_W * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_q;
    logic [W-1:0]    bp_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic            cout_q;
    logic            ovf_q;

    logic [W-1:0]       b_eff;
    logic               c_init;
    logic [NIB_W-1:0]   x_nib;
    logic [NIB_W-1:0]   y_nib;
    logic [NIB_W-1:0]   s_nib;
    logic               co;
    logic               last;
    logic [IDXW+1:0]    base;

    // Subtraction is A + ~B + 1, so the inverted operand and forced carry are captured at start.
`ifdef NSA_ADDSUB_EN
    assign b_eff  = bus.op ? ~bus.b : bus.b;
    assign c_init = bus.op ? 1'b1 : bus.cin;
`else
    assign b_eff  = bus.b;
    assign c_init = bus.cin;
`endif

    assign base  = {idx, 2'b00};
    assign x_nib = a_q[base +: NIB_W];
    assign y_nib = bp_q[base +: NIB_W];
    assign last  = (idx == IDXW'(NIBBLES - 1));

    adder4_slice u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (co)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_q     <= '0;
            bp_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        bp_q    <= b_eff;
                        carry_q <= c_init;
                        idx     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[base +: NIB_W] <= s_nib;
                    carry_q              <= co;
                    idx                  <= idx + 1'b1;
                    // The slice sum MSB on the final nibble is the result sign bit.
                    if (last) begin
                        cout_q <= co;
                        ovf_q  <= (a_q[W-1] == bp_q[W-1]) && (s_nib[NIB_W-1] != a_q[W-1]);
                        idx    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl with NIBBLES=4.
// Subtract vectors are exercised only when NSA_ADDSUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic opv);
        bus.a   = av;
        bus.b   = bv;
        bus.cin = cv;
`ifdef NSA_ADDSUB_EN
        bus.op  = opv;
`else
        if (opv) $display("[TB] op ignored in add-only build");
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Fixed-latency walk through one operation, scrambling operands after acceptance.
    task automatic runAndCheck(input string tag, input logic [15:0] av, input logic [15:0] bv,
                               input logic cv, input logic opv,
                               input logic [15:0] expSum, input logic expCout, input logic expOvf);
        applyStimulus(av, bv, cv, opv);
        checkOutput({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_sumclr_e0"}, 32'(bus.sum), 32'd0);
        bus.a = ~av;
        bus.b = av ^ bv;
        bus.cin = ~cv;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
            checkOutput({tag, "_done_run"}, 32'(bus.done), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(expCout));
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(expOvf));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_sum_hold"}, 32'(bus.sum), 32'(expSum));
        checkOutput({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int doneCount;
        int phase;

        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef NSA_ADDSUB_EN
        bus.op    = 1'b0;
`endif
        #23;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_sum", 32'(bus.sum), 32'd0);
        checkOutput("rst_cout", 32'(bus.cout), 32'd0);
        checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] basic add vectors");
        runAndCheck("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        runAndCheck("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runAndCheck("ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

        $display("[TB] start held high for 20 cycles");
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        doneCount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            phase = k % 6;
            checkOutput("held_busy", 32'(bus.busy), (phase < 4) ? 32'd1 : 32'd0);
            checkOutput("held_done", 32'(bus.done), (phase == 4) ? 32'd1 : 32'd0);
            if (bus.done === 1'b1) begin
                doneCount++;
                checkOutput("held_sum", 32'(bus.sum), 32'h3333);
            end
            if (phase < 4) begin
                bus.a = 16'hABCD;
                bus.b = 16'h5A5A;
                bus.cin = 1'b1;
            end else begin
                bus.a = 16'h1111;
                bus.b = 16'h2222;
                bus.cin = 1'b0;
            end
        end
        checkOutput("held_done_count", 32'(doneCount), 32'd3);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("held_quiet_busy", 32'(bus.busy), 32'd0);

        $display("[TB] reset during RUN");
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midrun_partial", 32'(bus.sum), 32'h0005);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_sum", 32'(bus.sum), 32'd0);
        checkOutput("midrst_cout", 32'(bus.cout), 32'd0);
        checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_idle", 32'(bus.busy), 32'd0);
        runAndCheck("postrst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef NSA_ADDSUB_EN
        $display("[TB] subtract vectors");
        runAndCheck("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runAndCheck("sub2", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runAndCheck("addback", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that time-shares a single 4-bit ripple-carry adder slice to add, or optionally subtract, wide operands one nibble per clock. It latches the operands on a start request and walks the nibbles LSB-first, carrying between cycles in a register. It reports the result with a busy/done handshake. It sits between the switch/operand registers and the LED/result display, replacing a wide combinational adder with one reused slice.

## Interface
- `NIBBLES`, default 4: operands are 4·NIBBLES bits wide; legal range is 2..8.
- `clk` input, 1: single clock, rising edge.
- `resetn` input, 1: reset, asynchronous, active-low.
- `start` input, 1: request; sampled only in IDLE.
- `a` input, 4·NIBBLES: operand A, latched on the accepted start.
- `b` input, 4·NIBBLES: operand B, latched on the accepted start.
- `cin` input, 1: carry-in, latched on the accepted start.
- `op` input, 1: 0 = add, 1 = subtract. Present only with `NSA_ADDSUB_EN`.
- `busy` output, 1: high while in RUN.
- `done` output, 1: one-cycle pulse when the result is valid.
- `sum` output, 4·NIBBLES: result register.
- `cout` output, 1: carry out of the MSB nibble.
- `ovf` output, 1: two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE, start=1: latch `a`, `b` and the carry-in into operand registers. Set nibble index `idx` to 0. Clear `sum`, `cout` and `ovf`. Go to RUN.
- IDLE, start=0: stay in IDLE. Result registers hold.
- RUN, each cycle:
  - Feed nibble `idx` of A, nibble `idx` of B', and the carry register to the adder slice.
  - Write the slice sum into `sum[4·idx+3:4·idx]`.
  - Write the slice carry-out into the carry register.
  - Increment `idx`.
- RUN, on the cycle where idx = NIBBLES−1:
  - `cout` ← slice carry-out.
  - `ovf` ← (A_msb == B'_msb) && (sum_msb != A_msb).
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle, then unconditionally go to IDLE.
- B' = B, except that under subtract it is ~B (see Configuration).
- All arithmetic is modulo 2^(4·NIBBLES). No saturation.
- `start` in RUN or DONE is ignored. No queuing.
- `start` held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Operand inputs may change freely after acceptance without affecting the operation in progress.
- `sum`, `cout` and `ovf` hold their values from DONE until the next accepted start.
- Reset, asynchronous at any time including mid-RUN:
  - State goes to IDLE; idx goes to 0.
  - `busy`, `done`, `sum`, `cout` and `ovf` all go to 0.
  - Operand and carry registers go to 0.
  - The partial result is discarded.

## Timing
- Edge E0 samples start=1 in IDLE. `busy` rises after E0.
- Edges E1..E_NIBBLES each process one nibble.
- `busy` falls and `done` rises after edge E_NIBBLES.
- `done` falls after edge E_NIBBLES+1, when the FSM is back in IDLE.
- Throughput is one operation per NIBBLES+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `NSA_ADDSUB_EN` defined:
  - The `op` port exists.
  - With op=1 latched: B' = ~B, and the initial carry is forced to 1 (`cin` is ignored).
  - With op=0: the block behaves as a plain adder.
- `NSA_ADDSUB_EN` undefined:
  - No `op` port.
  - B' = B and the initial carry = `cin`.

## Structure
- Shared package `nsa_pkg`: FSM state encoding constants (IDLE, RUN, DONE) and the nibble-width constant 4.
- One sub-module, `adder4_slice`:
  - Combinational 4-bit ripple adder.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], co.
  - Built from four full-adder cells.
  - The controller instantiates exactly one.

## Test plan
- NIBBLES=4, a=0x1234, b=0x0FFF, cin=0 → sum=0x2233, cout=0, ovf=0. `busy` high for 4 cycles, `done` one cycle after that.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Checks carry ripple across all nibble boundaries.
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Hold start=1 for 20 cycles with fixed operands → exactly one `done` per 6 cycles. Operand changes during RUN do not alter the in-flight result.
- Pulse resetn low during the 2nd RUN cycle → all outputs 0 immediately, FSM in IDLE. The next start with a=0x0001, b=0x0001 → sum=0x0002.
- With `NSA_ADDSUB_EN`, op=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
